// File: rtl/pe_vec_acc.sv
// rtl/pe_vec_acc.sv - multi-lane fixed-point MAC / elementwise / accumulate processing element
// Two-stage pipeline: S1 registers per-lane products and sums, S2 accumulates, saturates and requantizes.
module pe_vec_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     mode,
  input  logic [CNT_WIDTH-1:0]           acc_len,
  input  logic [LANES*DATA_WIDTH-1:0]    a_in,
  input  logic [LANES*DATA_WIDTH-1:0]    b_in,
  input  logic [LANES*ACC_WIDTH-1:0]     acc_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*ACC_WIDTH-1:0]     result_out,
  output logic [LANES*DATA_WIDTH-1:0]    sat_out,
  output logic [LANES-1:0]               ovf_out
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int CW = CNT_WIDTH;

  localparam logic [1:0] MODE_MAC = 2'b00;
  localparam logic [1:0] MODE_EWM = 2'b01;
  localparam logic [1:0] MODE_EWA = 2'b10;
  localparam logic [1:0] MODE_ACC = 2'b11;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [AW:0]   Q_MAX   = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0]   Q_MIN   = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [AW:0]   HALF    = (AW+1)'(1) << (FRAC_BITS-1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    len_q;
  logic             accept;

  logic             beat_acc;
  logic             beat_first;
  logic             beat_last;
  logic [CW-1:0]    len_eff;
  logic [CW-1:0]    cnt_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Group bookkeeping is resolved at acceptance so S2 only sees first/last tags.
  always_comb begin
    len_eff    = (acc_len == '0) ? CW'(1) : acc_len;
    beat_acc   = 1'b0;
    beat_first = 1'b0;
    beat_last  = 1'b0;
    cnt_next   = cnt;
    if (state == ACCUM) begin
      beat_acc  = 1'b1;
      cnt_next  = cnt + CW'(1);
      beat_last = (cnt_next == len_q);
    end else if (mode == MODE_ACC) begin
      beat_acc   = 1'b1;
      beat_first = 1'b1;
      cnt_next   = CW'(1);
      beat_last  = (len_eff == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
    end else if (accept && beat_acc) begin
      cnt <= cnt_next;
      if (state == IDLE) begin
        len_q <= len_eff;
      end
      state <= beat_last ? IDLE : ACCUM;
    end
  end

  logic signed [2*DW-1:0] prod_w [LANES];
  logic signed [DW:0]     sum_w  [LANES];
  logic signed [AW-1:0]   prod_c [LANES];
  logic signed [AW-1:0]   sum_c  [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_w[l] = $signed(a_in[l*DW +: DW]) * $signed(b_in[l*DW +: DW]);
      sum_w[l]  = $signed(a_in[l*DW +: DW]) + $signed(b_in[l*DW +: DW]);
      prod_c[l] = AW'(prod_w[l]);
      sum_c[l]  = AW'(sum_w[l]) <<< FRAC_BITS;
    end
  end

  logic                 s1_valid;
  logic                 s1_acc;
  logic                 s1_first;
  logic                 s1_last;
  logic [1:0]           s1_mode;
  logic signed [AW-1:0] s1_prod  [LANES];
  logic signed [AW-1:0] s1_sum   [LANES];
  logic signed [AW-1:0] s1_accin [LANES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_acc   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= MODE_MAC;
      for (int l = 0; l < LANES; l++) begin
        s1_prod[l]  <= '0;
        s1_sum[l]   <= '0;
        s1_accin[l] <= '0;
      end
    end else if (in_ready) begin
      s1_valid <= accept;
      s1_acc   <= accept && beat_acc;
      s1_first <= beat_first;
      s1_last  <= beat_last;
      s1_mode  <= mode;
      for (int l = 0; l < LANES; l++) begin
        s1_prod[l]  <= prod_c[l];
        s1_sum[l]   <= sum_c[l];
        s1_accin[l] <= acc_in[l*AW +: AW];
      end
    end
  end

  logic signed [AW-1:0] acc_q [LANES];
  logic [LANES-1:0]     acc_ovf_q;

  logic signed [AW-1:0] add_x   [LANES];
  logic signed [AW:0]   add_w   [LANES];
  logic signed [AW-1:0] sat_sum [LANES];
  logic                 clip    [LANES];
  logic signed [AW-1:0] res_c   [LANES];
  logic [LANES-1:0]     ovf_c;
  logic signed [AW:0]   rnd_w   [LANES];
  logic signed [AW:0]   rnd_sh  [LANES];
  logic [DW-1:0]        sat_c   [LANES];
  logic                 s2_emit;

  assign s2_emit = s1_valid && (!s1_acc || s1_last);

  // One shared saturating adder per lane serves both MAC and the ACC accumulator.
  always_comb begin
    ovf_c = '0;
    for (int l = 0; l < LANES; l++) begin
      add_x[l] = s1_accin[l];
      if (s1_acc) begin
        add_x[l] = s1_first ? '0 : acc_q[l];
      end
      add_w[l]   = {add_x[l][AW-1], add_x[l]} + {s1_prod[l][AW-1], s1_prod[l]};
      clip[l]    = add_w[l][AW] != add_w[l][AW-1];
      sat_sum[l] = clip[l] ? (add_w[l][AW] ? ACC_MIN : ACC_MAX) : add_w[l][AW-1:0];
      res_c[l]   = sat_sum[l];
      if (s1_acc) begin
        ovf_c[l] = clip[l] | (!s1_first & acc_ovf_q[l]);
      end else begin
        case (s1_mode)
          MODE_EWM: res_c[l] = s1_prod[l];
          MODE_EWA: res_c[l] = s1_sum[l];
          default:  ovf_c[l] = clip[l];
        endcase
      end
      rnd_w[l]  = {res_c[l][AW-1], res_c[l]} + HALF;
      rnd_sh[l] = rnd_w[l] >>> FRAC_BITS;
      if (rnd_sh[l] > Q_MAX) begin
        sat_c[l] = {1'b0, {(DW-1){1'b1}}};
      end else if (rnd_sh[l] < Q_MIN) begin
        sat_c[l] = {1'b1, {(DW-1){1'b0}}};
      end else begin
        sat_c[l] = rnd_sh[l][DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result_out <= '0;
      sat_out    <= '0;
      ovf_out    <= '0;
      acc_ovf_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
    end else if (in_ready) begin
      out_valid <= s2_emit;
      if (s1_valid && s1_acc) begin
        acc_ovf_q <= ovf_c;
        for (int l = 0; l < LANES; l++) begin
          acc_q[l] <= res_c[l];
        end
      end
      if (s2_emit) begin
        ovf_out <= ovf_c;
        for (int l = 0; l < LANES; l++) begin
          result_out[l*AW +: AW] <= res_c[l];
          sat_out[l*DW +: DW]    <= sat_c[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_vec_acc.sv
// tb/tb_pe_vec_acc.sv - self-checking bench for pe_vec_acc
// Behavioural model predicts each emitted result and the enabled cycle it must appear on.
module tb_pe_vec_acc;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int FB = 8;
  localparam int L  = 4;
  localparam int CW = 8;
  localparam longint AMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint AMIN = -64'sh0000_0000_8000_0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      mode;
  logic [CW-1:0]   acc_len;
  logic [L*DW-1:0] a_in;
  logic [L*DW-1:0] b_in;
  logic [L*AW-1:0] acc_in;
  logic            out_valid;
  logic            out_ready;
  logic [L*AW-1:0] result_out;
  logic [L*DW-1:0] sat_out;
  logic [L-1:0]    ovf_out;

  always #5 clk = ~clk;

  pe_vec_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(FB), .LANES(L), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .acc_len(acc_len), .a_in(a_in), .b_in(b_in), .acc_in(acc_in), .out_valid(out_valid),
    .out_ready(out_ready), .result_out(result_out), .sat_out(sat_out), .ovf_out(ovf_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [L*AW-1:0] res;
    logic [L*DW-1:0] sat;
    logic [L-1:0]    ovf;
    int              due;
  } exp_t;

  exp_t   q[$];
  int     en_cnt = 0;
  bit     m_grp = 0;
  int     m_len;
  int     m_cnt;
  longint m_acc [L];
  bit     m_ovf [L];

  function automatic longint sat_acc(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  function automatic logic [DW-1:0] requant(input longint r);
    longint t;
    t = (r + (longint'(1) << (FB-1))) >>> FB;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t[DW-1:0];
  endfunction

  task automatic model_beat();
    exp_t   e;
    longint a, b, c, p, r;
    bit     is_acc, emit;
    e.res = '0; e.sat = '0; e.ovf = '0;
    is_acc = m_grp || (mode == 2'b11);
    if (is_acc && !m_grp) begin
      m_grp = 1;
      m_len = (acc_len == 0) ? 1 : int'(acc_len);
      m_cnt = 0;
      for (int l = 0; l < L; l++) begin m_acc[l] = 0; m_ovf[l] = 0; end
    end
    if (is_acc) m_cnt++;
    for (int l = 0; l < L; l++) begin
      a = longint'($signed(a_in[l*DW +: DW]));
      b = longint'($signed(b_in[l*DW +: DW]));
      c = longint'($signed(acc_in[l*AW +: AW]));
      p = a * b;
      if (is_acc) begin
        r = sat_acc(m_acc[l] + p);
        if (r != m_acc[l] + p) m_ovf[l] = 1;
        m_acc[l] = r;
        e.ovf[l] = m_ovf[l];
      end else if (mode == 2'b00) begin
        r = sat_acc(c + p);
        e.ovf[l] = (r != c + p);
      end else if (mode == 2'b01) begin
        r = p;
      end else begin
        r = (a + b) * 256;
      end
      e.res[l*AW +: AW] = r[AW-1:0];
      e.sat[l*DW +: DW] = requant(r);
    end
    emit = !is_acc || (m_cnt == m_len);
    if (is_acc && emit) m_grp = 0;
    e.due = en_cnt + 1;
    if (emit) q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_grp = 0;
    end else begin
      chk("in_ready_rule", 128'(in_ready), 128'(!out_valid || out_ready));
      if (out_valid) begin
        if (q.size() == 0 || q[0].due != en_cnt) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got result %0h at enabled cycle %0d, queue %0d", result_out, en_cnt, q.size());
        end else begin
          chk("model_result", 128'(result_out), 128'(q[0].res));
          chk("model_sat", 128'(sat_out), 128'(q[0].sat));
          chk("model_ovf", 128'(ovf_out), 128'(q[0].ovf));
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].due <= en_cnt) begin
        checks++; errors++;
        $display("FAIL missing_out_valid: got out_valid 0 expected 1 at enabled cycle %0d", en_cnt);
        void'(q.pop_front());
      end
      if (in_ready) begin
        en_cnt++;
        if (in_valid) model_beat();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [CW-1:0] len, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [AW-1:0] c);
    int n = 0;
    mode = m; acc_len = len; a_in = {L{a}}; b_in = {L{b}}; acc_in = {L{c}};
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [AW-1:0] r, input logic [DW-1:0] s, input logic o);
    int n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    chk({nm, "_latency"}, 128'(n), 128'(2));
    chk({nm, "_result"}, 128'(result_out[AW-1:0]), 128'(r));
    chk({nm, "_sat"}, 128'(sat_out[DW-1:0]), 128'(s));
    chk({nm, "_ovf"}, 128'(ovf_out[0]), 128'(o));
    step();
  endtask

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0100;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [L*AW-1:0] cap;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; acc_len = '0;
    a_in = '0; b_in = '0; acc_in = '0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_result", 128'(result_out), 128'(0));
    chk("reset_sat", 128'(sat_out), 128'(0));
    chk("reset_ovf", 128'(ovf_out), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    step();

    send(2'b00, 8'd0, 16'h0200, 16'h0180, 32'h0001_0000);
    expect_out("mac", 32'h0004_0000, 16'h0400, 1'b0);
    send(2'b10, 8'd0, 16'h7FFF, 16'h0001, 32'h0);
    expect_out("ewa", 32'h0080_0000, 16'h7FFF, 1'b0);
    send(2'b01, 8'd0, 16'hFF00, 16'h0200, 32'h0);
    expect_out("ewm", 32'hFFFE_0000, 16'hFE00, 1'b0);

    for (int k = 0; k < 4; k++) send(2'b11, 8'd4, 16'h0100, 16'h0100, 32'h0);
    expect_out("acc4", 32'h0004_0000, 16'h0400, 1'b0);
    @(negedge clk);
    chk("acc4_single_out", 128'(out_valid), 128'(0));
    step();

    for (int k = 0; k < 2; k++) send(2'b11, 8'd2, 16'h8000, 16'h8000, 32'h0);
    expect_out("acc2_sat", 32'h7FFF_FFFF, 16'h7FFF, 1'b1);

    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(2'b01, 8'd0, DW'(k * 256), 16'h0100, 32'h0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin n++; @(negedge clk); end
        cap = result_out;
        chk("stall_first_result", 128'(cap[AW-1:0]), 128'(32'h0001_0000));
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 128'(in_ready), 128'(0));
          chk("stall_hold", 128'(result_out), 128'(cap));
        end
        step();
        out_ready = 1'b1;
      end
    join
    repeat (6) step();
    chk("stall_drained", 128'(q.size()), 128'(0));

    send(2'b11, 8'd4, 16'h0100, 16'h0100, 32'h0);
    send(2'b11, 8'd4, 16'h0100, 16'h0100, 32'h0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midgroup_reset_no_out", 128'(out_valid), 128'(0));
    end
    step();
    for (int k = 0; k < 4; k++) send(2'b11, 8'd4, 16'h0100, 16'h0100, 32'h0);
    expect_out("after_reset_acc4", 32'h0004_0000, 16'h0400, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom_range(0, 3));
      acc_len   = CW'($urandom_range(0, 5));
      for (int l = 0; l < L; l++) begin
        a_in[l*DW +: DW] = rnd_op();
        b_in[l*DW +: DW] = rnd_op();
        case ($urandom_range(0, 3))
          0: acc_in[l*AW +: AW] = 32'h7FFF_0000;
          1: acc_in[l*AW +: AW] = 32'h8000_0000;
          default: acc_in[l*AW +: AW] = $urandom;
        endcase
      end
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();
    chk("final_drained", 128'(q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
